// File: rtl/shift_pkg.sv
// Shared types for the shift controller: operation codes and FSM states.
// Imported by the interface, the step datapath and the controller.
package shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_ctrl_if.sv
// Command/result handshake bundle between a requester/consumer
// (master) and the shift controller (slave).
import shift_pkg::*;

interface shift_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic             in_valid;
  logic             in_ready;
  op_e              in_op;
  logic [AMT_W-1:0] in_amt;
  logic [WIDTH-1:0] in_data;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_op, in_amt, in_data,
    output abort, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_op, in_amt, in_data,
    input  abort, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/shift_step.sv
// One-bit shift/rotate step, purely combinational.
// Applied once per SHIFT cycle by the controller.
import shift_pkg::*;

module shift_step #(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_comb begin
    q = d;
    unique case (op)
      SLL: q = {d[WIDTH-2:0], 1'b0};
      SRL: q = {1'b0, d[WIDTH-1:1]};
      SRA: q = {d[WIDTH-1], d[WIDTH-1:1]};
      ROL: q = {d[WIDTH-2:0], d[WIDTH-1]};
      default: q = d;
    endcase
  end

endmodule

// File: rtl/shift_ctrl.sv
// Multi-cycle shifter: accepts a command, steps one bit per cycle,
// then holds the result until the consumer takes it or it is aborted.
import shift_pkg::*;

module shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input logic         clk,
  input logic         rst,
  shift_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [AMT_W-1:0] amt_eff;
  logic [WIDTH-1:0] step_q;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op (op_q),
    .d  (data_q),
    .q  (step_q)
  );

  // Shifts saturate at WIDTH; rotates wrap since WIDTH is a power of two.
  always_comb begin
    amt_eff = bus.in_amt;
    if (bus.in_op == ROL)
      amt_eff = bus.in_amt & AMT_W'(WIDTH - 1);
    else if (bus.in_amt > AMT_W'(WIDTH))
      amt_eff = AMT_W'(WIDTH);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.in_op;
          data_d  = bus.in_data;
          cnt_d   = amt_eff;
          state_d = (amt_eff == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          data_d = step_q;
          if (cnt_q != '0)
            cnt_d = cnt_q - AMT_W'(1);
          if (cnt_q <= AMT_W'(1))
            state_d = DONE;
        end
      end
      DONE: begin
        if (bus.abort || bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= SLL;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = (state_q == DONE) ? data_q : '0;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed self-checking bench for shift_ctrl at WIDTH=8.
import shift_pkg::*;

module tb_shift_ctrl;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  shift_ctrl_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  shift_ctrl #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command at a negedge, measure edges to out_valid, drain.
  task automatic run_cmd(string tag, op_e op, logic [3:0] amt,
                         logic [7:0] d, logic [7:0] exp_d, int exp_lat);
    int n;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_amt   = amt;
    bus.in_data  = d;
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_data"}, 32'(bus.out_data), 32'(exp_d));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = SLL;
    bus.in_amt    = '0;
    bus.in_data   = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_cmd("sll3", SLL, 4'd3, 8'h81, 8'h08, 3);
    run_cmd("sra2", SRA, 4'd2, 8'h90, 8'hE4, 2);
    run_cmd("srl12", SRL, 4'd12, 8'hFF, 8'h00, 8);
    run_cmd("rol9", ROL, 4'd9, 8'h81, 8'h03, 1);
    run_cmd("sll0", SLL, 4'd0, 8'h5A, 8'h5A, 0);
    run_cmd("srl0", SRL, 4'd0, 8'h5A, 8'h5A, 0);
    run_cmd("sra0", SRA, 4'd0, 8'h5A, 8'h5A, 0);
    run_cmd("rol0", ROL, 4'd0, 8'h5A, 8'h5A, 0);
    run_cmd("rol8", ROL, 4'd8, 8'h5A, 8'h5A, 0);
    run_cmd("sra15", SRA, 4'd15, 8'h80, 8'hFF, 8);
    run_cmd("srl1", SRL, 4'd1, 8'h80, 8'h40, 1);
    run_cmd("rol3", ROL, 4'd3, 8'hB4, 8'hA5, 3);
    run_cmd("sll8", SLL, 4'd8, 8'hFF, 8'h00, 8);

    // Backpressure: result held, stray in_valid pulses ignored.
    bus.in_valid = 1'b1;
    bus.in_op    = SLL;
    bus.in_amt   = 4'd1;
    bus.in_data  = 8'h01;
    @(negedge clk);
    bus.in_data  = 8'hAA;
    @(negedge clk);
    chk("bp_valid0", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = 8'h30 + 8'(i);
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_data", 32'(bus.out_data), 32'h02);
      chk("bp_no_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_idle", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("bp_no_accept", 32'(bus.busy), 32'd0);

    // Abort on the second SHIFT cycle.
    bus.in_valid = 1'b1;
    bus.in_op    = SRL;
    bus.in_amt   = 4'd5;
    bus.in_data  = 8'hF0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("ab_shift1", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("ab_shift2", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("ab_idle", 32'(bus.busy), 32'd0);
    chk("ab_no_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ab_quiet", 32'(bus.out_valid), 32'd0);
    end

    // Abort together with out_ready in DONE drops the result.
    bus.in_valid = 1'b1;
    bus.in_op    = SLL;
    bus.in_amt   = 4'd0;
    bus.in_data  = 8'h77;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("abd_valid", 32'(bus.out_valid), 32'd1);
    bus.abort     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    chk("abd_idle", 32'(bus.busy), 32'd0);
    chk("abd_data", 32'(bus.out_data), 32'd0);

    // Abort is ignored in IDLE, but still cancels once in SHIFT.
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = SRA;
    bus.in_amt   = 4'd2;
    bus.in_data  = 8'h80;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("abi_accept", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abi_cancel", 32'(bus.busy), 32'd0);
    chk("abi_no_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of SHIFT acts immediately.
    bus.in_valid = 1'b1;
    bus.in_op    = SRL;
    bus.in_amt   = 4'd6;
    bus.in_data  = 8'hC3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rs_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_busy", 32'(bus.busy), 32'd0);
    chk("rs_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rs_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rs_out_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_cmd("rs_after", SLL, 4'd3, 8'h81, 8'h08, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
